// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Free-running column/row counters, combinational coordinate and strobe
// decodes, and active-low hs/vs registered once and then delayed SYNC_DLY
// more cycles so sync lines up with the renderer's registered RGB.
// Both totals must be <= 1024 so the 10-bit counters can hold them.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SYNC_DLY  = 1
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS_W  = 10'(H_VISIBLE);
   localparam logic [9:0]  V_VIS_W  = 10'(V_VISIBLE);
   // Sync window bounds can reach 1024, so compare on 11 bits.
   localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0]        hc_q, hc_d;
   logic [9:0]        vc_q, vc_d;
   // Bit 0 is the raw sync register; bits 1..SYNC_DLY are the delay stages.
   logic [SYNC_DLY:0] hs_pipe_q, hs_pipe_d;
   logic [SYNC_DLY:0] vs_pipe_q, vs_pipe_d;

   // Next-state for the column/row counters: wrap only at the totals.
   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end
   end

   // Next-state for the sync pipelines: raw decode of the current counters
   // enters stage 0, every later stage takes its predecessor.
   always_comb begin
      hs_pipe_d    = hs_pipe_q;
      vs_pipe_d    = vs_pipe_q;
      hs_pipe_d[0] = ~(({1'b0, hc_q} >= HS_BEGIN) && ({1'b0, hc_q} < HS_END));
      vs_pipe_d[0] = ~(({1'b0, vc_q} >= VS_BEGIN) && ({1'b0, vc_q} < VS_END));
      for (int i = 1; i <= SYNC_DLY; i++) begin
         hs_pipe_d[i] = hs_pipe_q[i-1];
         vs_pipe_d[i] = vs_pipe_q[i-1];
      end
   end

   // Counter state; reset parks the raster at the top-left pixel.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Sync state; every stage resets to the inactive (high) level.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
      end else begin
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
      end
   end

   // Coordinates and strobes are pure decodes of the counters so renderers
   // see them on the same edge they change; consumers gate with blank.
   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign blank       = (hc_q < H_VIS_W) && (vc_q < V_VIS_W);
   assign line_start  = (hc_q == '0);
   assign frame_start = (hc_q == '0) && (vc_q == '0);
   assign hs          = hs_pipe_q[SYNC_DLY];
   assign vs          = vs_pipe_q[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three builds of vga_timing_gen run side by side.
//   0: default 640x480 timing, SYNC_DLY=1
//   1: default line timing, 8-line frame, SYNC_DLY=1 (reaches vs/frame wrap quickly)
//   2: tiny 16x11 raster, SYNC_DLY=0
// A cycle model per build queues the expected sync levels as each counter
// value is presented and pops them when they must appear on hs/vs.
module tb_vga_timing_gen;

   localparam int N = 3;
   localparam int HVIS [N] = '{640, 640, 8};
   localparam int HFP  [N] = '{16, 16, 2};
   localparam int HSY  [N] = '{96, 96, 3};
   localparam int HBP  [N] = '{48, 48, 3};
   localparam int VVIS [N] = '{480, 4, 6};
   localparam int VFP  [N] = '{10, 1, 1};
   localparam int VSY  [N] = '{2, 2, 2};
   localparam int VBP  [N] = '{33, 1, 2};
   localparam int DLY  [N] = '{1, 1, 0};

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] dx [N];
   logic [9:0] dy [N];
   logic       bl [N];
   logic       hs [N];
   logic       vs [N];
   logic       ls [N];
   logic       fs [N];

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   always #20 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_VISIBLE(HVIS[0]), .H_FP(HFP[0]), .H_SYNC(HSY[0]), .H_BP(HBP[0]),
      .V_VISIBLE(VVIS[0]), .V_FP(VFP[0]), .V_SYNC(VSY[0]), .V_BP(VBP[0]),
      .SYNC_DLY(DLY[0])
   ) dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
      .blank(bl[0]), .hs(hs[0]), .vs(vs[0]), .line_start(ls[0]), .frame_start(fs[0])
   );

   vga_timing_gen #(
      .H_VISIBLE(HVIS[1]), .H_FP(HFP[1]), .H_SYNC(HSY[1]), .H_BP(HBP[1]),
      .V_VISIBLE(VVIS[1]), .V_FP(VFP[1]), .V_SYNC(VSY[1]), .V_BP(VBP[1]),
      .SYNC_DLY(DLY[1])
   ) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
      .blank(bl[1]), .hs(hs[1]), .vs(vs[1]), .line_start(ls[1]), .frame_start(fs[1])
   );

   vga_timing_gen #(
      .H_VISIBLE(HVIS[2]), .H_FP(HFP[2]), .H_SYNC(HSY[2]), .H_BP(HBP[2]),
      .V_VISIBLE(VVIS[2]), .V_FP(VFP[2]), .V_SYNC(VSY[2]), .V_BP(VBP[2]),
      .SYNC_DLY(DLY[2])
   ) dut2 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
      .blank(bl[2]), .hs(hs[2]), .vs(vs[2]), .line_start(ls[2]), .frame_start(fs[2])
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, obs, exp);
      end
   endtask

   // Model state and scoreboard queues.
   int m_hc [N];
   int m_vc [N];
   int hs_sb [N][$];
   int vs_sb [N][$];

   // Independent timing trackers.
   int t_hx [N], t_vy [N], last_hf [N], last_vf [N], last_fs [N];
   int hlow_n [N], vlow_n [N], n_hf [N], n_vf [N], n_fs [N];
   bit in_hlow [N], in_vlow [N];
   bit p_hs [N], p_vs [N], p_fs [N];

   initial begin : scoreboard
      int ht, vt, e_hs, e_vs;
      forever begin
         @(negedge vga_clk);
         cyc++;
         for (int i = 0; i < N; i++) begin
            ht = HVIS[i] + HFP[i] + HSY[i] + HBP[i];
            vt = VVIS[i] + VFP[i] + VSY[i] + VBP[i];
            if (!reset_n) begin
               m_hc[i] = 0;
               m_vc[i] = 0;
               hs_sb[i].delete();
               vs_sb[i].delete();
               for (int k = 0; k <= DLY[i]; k++) begin
                  hs_sb[i].push_back(1);
                  vs_sb[i].push_back(1);
               end
               in_hlow[i] = 0; in_vlow[i] = 0;
               last_hf[i] = -1; last_vf[i] = -1; last_fs[i] = -1;
               t_hx[i] = -1; t_vy[i] = -1;
               p_hs[i] = 1; p_vs[i] = 1; p_fs[i] = 0;
            end
            e_hs = (hs_sb[i].size() > 0) ? hs_sb[i].pop_front() : 2;
            e_vs = (vs_sb[i].size() > 0) ? vs_sb[i].pop_front() : 2;
            chk_eq($sformatf("DrawX[%0d]", i), dx[i], m_hc[i]);
            chk_eq($sformatf("DrawY[%0d]", i), dy[i], m_vc[i]);
            chk_eq($sformatf("blank[%0d]", i), bl[i], (m_hc[i] < HVIS[i] && m_vc[i] < VVIS[i]) ? 1 : 0);
            chk_eq($sformatf("line_start[%0d]", i), ls[i], (m_hc[i] == 0) ? 1 : 0);
            chk_eq($sformatf("frame_start[%0d]", i), fs[i], (m_hc[i] == 0 && m_vc[i] == 0) ? 1 : 0);
            chk_eq($sformatf("hs[%0d]", i), hs[i], e_hs);
            chk_eq($sformatf("vs[%0d]", i), vs[i], e_vs);
            hs_sb[i].push_back((m_hc[i] >= HVIS[i] + HFP[i] && m_hc[i] < HVIS[i] + HFP[i] + HSY[i]) ? 0 : 1);
            vs_sb[i].push_back((m_vc[i] >= VVIS[i] + VFP[i] && m_vc[i] < VVIS[i] + VFP[i] + VSY[i]) ? 0 : 1);
            if (m_hc[i] == ht - 1) begin
               m_hc[i] = 0;
               m_vc[i] = (m_vc[i] == vt - 1) ? 0 : m_vc[i] + 1;
            end else begin
               m_hc[i] = m_hc[i] + 1;
            end

            if (reset_n) begin
               // hs edge timing measured from the DUT's own coordinates
               if (dx[i] == 10'(HVIS[i] + HFP[i])) t_hx[i] = cyc;
               if (p_hs[i] && !hs[i]) begin
                  chk_eq($sformatf("hs_fall_lat[%0d]", i), cyc - t_hx[i], 1 + DLY[i]);
                  if (last_hf[i] >= 0) chk_eq($sformatf("hs_period[%0d]", i), cyc - last_hf[i], ht);
                  last_hf[i] = cyc; in_hlow[i] = 1; hlow_n[i] = 0; n_hf[i]++;
               end
               if (!p_hs[i] && hs[i] && in_hlow[i])
                  chk_eq($sformatf("hs_low_len[%0d]", i), hlow_n[i], HSY[i]);
               if (!hs[i]) hlow_n[i]++;
               // vs edge timing
               if (dx[i] == 0 && dy[i] == 10'(VVIS[i] + VFP[i])) t_vy[i] = cyc;
               if (p_vs[i] && !vs[i]) begin
                  chk_eq($sformatf("vs_fall_lat[%0d]", i), cyc - t_vy[i], 1 + DLY[i]);
                  if (last_vf[i] >= 0) chk_eq($sformatf("vs_period[%0d]", i), cyc - last_vf[i], ht * vt);
                  last_vf[i] = cyc; in_vlow[i] = 1; vlow_n[i] = 0; n_vf[i]++;
               end
               if (!p_vs[i] && vs[i] && in_vlow[i])
                  chk_eq($sformatf("vs_low_len[%0d]", i), vlow_n[i], VSY[i] * ht);
               if (!vs[i]) vlow_n[i]++;
               // frame_start is one cycle wide, once per frame
               if (fs[i]) begin
                  chk_eq($sformatf("fs_width[%0d]", i), p_fs[i], 0);
                  if (last_fs[i] >= 0) chk_eq($sformatf("fs_period[%0d]", i), cyc - last_fs[i], ht * vt);
                  last_fs[i] = cyc; n_fs[i]++;
               end
               // blank corner points
               if (dx[i] == 10'(HVIS[i] - 1) && dy[i] == 10'(VVIS[i] - 1))
                  chk_eq($sformatf("blank_corner[%0d]", i), bl[i], 1);
               if (dx[i] == 10'(HVIS[i]) && dy[i] == 0)
                  chk_eq($sformatf("blank_right[%0d]", i), bl[i], 0);
               if (dx[i] == 0 && dy[i] == 10'(VVIS[i]))
                  chk_eq($sformatf("blank_below[%0d]", i), bl[i], 0);
               p_hs[i] = hs[i]; p_vs[i] = vs[i]; p_fs[i] = fs[i];
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int guard;
      for (int i = 0; i < N; i++) begin
         n_hf[i] = 0; n_vf[i] = 0; n_fs[i] = 0;
      end
      repeat (3) @(negedge vga_clk);
      #1 reset_n = 1'b1;

      // run to (300,2) on the default build, then reset mid-frame
      guard = 0;
      while (!(dx[0] == 10'd300 && dy[0] == 10'd2) && guard < 5000) begin
         @(negedge vga_clk);
         guard++;
      end
      chk_eq("reach_300_2", (guard < 5000) ? 1 : 0, 1);
      #1 reset_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk_eq($sformatf("rst_DrawX[%0d]", i), dx[i], 0);
         chk_eq($sformatf("rst_DrawY[%0d]", i), dy[i], 0);
         chk_eq($sformatf("rst_hs[%0d]", i), hs[i], 1);
         chk_eq($sformatf("rst_vs[%0d]", i), vs[i], 1);
         chk_eq($sformatf("rst_blank[%0d]", i), bl[i], 1);
      end
      repeat (3) @(negedge vga_clk);
      #1 reset_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge vga_clk);
         #1 chk_eq("post_rst_DrawX", dx[0], k);
      end

      repeat (14000) @(negedge vga_clk);
      #1;
      chk_eq("hs_falls_seen0", (n_hf[0] >= 15) ? 1 : 0, 1);
      chk_eq("vs_falls_seen1", (n_vf[1] >= 2) ? 1 : 0, 1);
      chk_eq("fs_seen1", (n_fs[1] >= 2) ? 1 : 0, 1);
      chk_eq("hs_falls_seen2", (n_hf[2] >= 100) ? 1 : 0, 1);
      chk_eq("vs_falls_seen2", (n_vf[2] >= 50) ? 1 : 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
